// File: rtl/imm_gen_pipe_if.sv
// Handshake and data bundle for imm_gen_pipe: decode-side input stream,
// execute-side output stream and the illegal-format counter sideband.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_ext;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready, err_clr,
    output in_ready, out_valid, imm_ext, out_tag, illegal, err_cnt
  );

  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready, err_clr,
    input  in_ready, out_valid, imm_ext, out_tag, illegal, err_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: extends the immediate on the input side and
// stores only result/tag/flag in a one-stage pipe or a two-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] SRC_I   = 3'b000;
  localparam logic [2:0] SRC_S   = 3'b001;
  localparam logic [2:0] SRC_B   = 3'b010;
  localparam logic [2:0] SRC_J   = 3'b011;
  localparam logic [2:0] SRC_U   = 3'b100;
  localparam logic [2:0] SRC_Z   = 3'b101;
  localparam logic [2:0] SRC_SH  = 3'b110;
  localparam logic [2:0] SRC_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] f_extend(input logic [31:0] ins, input logic [2:0] src);
    logic [XLEN-1:0] imm;
    case (src)
      SRC_I:   imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
      SRC_S:   imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      SRC_B:   imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      SRC_J:   imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      SRC_U:   imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'h000};
      SRC_Z:   imm = {{(XLEN-5){1'b0}}, ins[19:15]};
      // RV64 shifts take a 6-bit shamt, RV32 only 5 bits
      SRC_SH:  imm = {{(XLEN-6){1'b0}}, ((XLEN == 64) ? ins[25] : 1'b0), ins[24:20]};
      default: imm = {XLEN{1'b0}};
    endcase
    return imm;
  endfunction

  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_imm      = f_extend(bus.instr, bus.imm_src);
  assign w_ill      = (bus.imm_src == SRC_ILL);
  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = w_out_valid & bus.out_ready;

  if (SKID != 0) begin : g_skid
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_ill;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;

    // Occupancy FSM: where an accepted entry lands and when the skid drains.
    always_comb begin
      w_state_nxt   = r_state;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_ONE;
            w_load_out  = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (!w_in_xfer && w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in_xfer && w_out_xfer) begin
            w_state_nxt = ST_ONE;
            w_load_out  = 1'b1;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt   = ST_ONE;
            w_skid_to_out = 1'b1;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end

    // State, registered in_ready (low through reset) and both entry slots.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b0;
        r_out_imm  <= {XLEN{1'b0}};
        r_out_tag  <= {TAG_W{1'b0}};
        r_out_ill  <= 1'b0;
        r_skid_imm <= {XLEN{1'b0}};
        r_skid_tag <= {TAG_W{1'b0}};
        r_skid_ill <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_in_ready <= (w_state_nxt != ST_FULL);
        if (w_load_out) begin
          r_out_imm <= w_imm;
          r_out_tag <= bus.in_tag;
          r_out_ill <= w_ill;
        end else if (w_skid_to_out) begin
          r_out_imm <= r_skid_imm;
          r_out_tag <= r_skid_tag;
          r_out_ill <= r_skid_ill;
        end
        if (w_load_skid) begin
          r_skid_imm <= w_imm;
          r_skid_tag <= bus.in_tag;
          r_skid_ill <= w_ill;
        end
      end
    end

    assign w_in_ready  = r_in_ready;
    assign w_out_valid = (r_state != ST_EMPTY);
  end else begin : g_pipe
    logic r_valid;
    logic r_rdy_en;

    // Single stage: refilled on acceptance, emptied when drained without refill.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid   <= 1'b0;
        r_rdy_en  <= 1'b0;
        r_out_imm <= {XLEN{1'b0}};
        r_out_tag <= {TAG_W{1'b0}};
        r_out_ill <= 1'b0;
      end else begin
        r_rdy_en <= 1'b1;
        if (w_in_xfer) begin
          r_valid   <= 1'b1;
          r_out_imm <= w_imm;
          r_out_tag <= bus.in_tag;
          r_out_ill <= w_ill;
        end else if (w_out_xfer) begin
          r_valid <= 1'b0;
        end
      end
    end

    // r_rdy_en keeps in_ready low during reset and until the first edge after it
    assign w_in_ready  = r_rdy_en & (~r_valid | bus.out_ready);
    assign w_out_valid = r_valid;
  end

  // Saturating count of accepted illegal entries; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= {CNT_W{1'b0}};
    end else if (bus.err_clr) begin
      r_err_cnt <= {CNT_W{1'b0}};
    end else if (w_in_xfer && w_ill && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.imm_ext   = r_out_imm;
  assign bus.out_tag   = r_out_tag;
  assign bus.illegal   = r_out_ill;
  assign bus.err_cnt   = r_err_cnt;

endmodule
